// File: rtl/bcd2bin_c.sv
// Serial reverse double-dabble: packed BCD in, unsigned binary out, one result bit per clock.
// Latency BIN_W+1 edges from accepted start to valid; start is ignored while busy.
module bcd2bin_c #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [BIN_W-1:0]      bin,
  output logic                  valid,
  output logic                  err,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int WRK_W = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic [WRK_W-1:0]   r_work;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err_pend;
  logic [BIN_W-1:0]   r_bin;
  logic               r_valid;
  logic               r_err;
  logic               r_busy;

  logic [WRK_W-1:0]   w_shift;
  logic [WRK_W-1:0]   w_adj;
  logic               w_bad;

  assign w_shift = r_work >> 1;

  // A digit >= 8 after the shift means a carry of 10 came down from above; remove the excess 3.
  always_comb begin
    w_adj = w_shift;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_shift[BIN_W + 4*i + 3])
        w_adj[BIN_W + 4*i +: 4] = w_shift[BIN_W + 4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9)
        w_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_work     <= '0;
      r_cnt      <= '0;
      r_err_pend <= 1'b0;
      r_bin      <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_work     <= {bcd, {BIN_W{1'b0}}};
            r_err_pend <= w_bad;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_work <= w_adj;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST_IT)
            r_state <= S_DONE;
        end
        S_DONE: begin
          r_bin   <= r_err_pend ? '0 : r_work[BIN_W-1:0];
          r_err   <= r_err_pend;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bin   = r_bin;
  assign valid = r_valid;
  assign err   = r_err;
  assign busy  = r_busy;

endmodule

// File: tb/tb_bcd2bin_c.sv
// Bench for bcd2bin_c: directed scenarios plus random legal BCD against a decimal model.
module tb_bcd2bin_c;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [15:0] bcd;
  logic [13:0] bin;
  logic        valid;
  logic        err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd2bin_c #(.DIGITS(4), .BIN_W(14)) dut (
    .clk   (clk),
    .nrst  (nrst),
    .start (start),
    .bcd   (bcd),
    .bin   (bin),
    .valid (valid),
    .err   (err),
    .busy  (busy)
  );

  // Reference: decimal value of the digits, or "bad" if any nibble is not a decimal digit.
  function automatic bit ref_bad(input logic [15:0] v);
    bit b = 1'b0;
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  function automatic int ref_bin(input logic [15:0] v);
    int acc = 0;
    if (ref_bad(v)) return 0;
    for (int i = 3; i >= 0; i--) acc = acc * 10 + int'(v[4*i +: 4]);
    return acc;
  endfunction

  // Drives one start pulse (caller is 1 time unit past a rising edge) and waits for valid.
  task automatic run_conv(input logic [15:0] v, output logic [13:0] b, output logic e,
                          output int lat, output bit busy_ok);
    start = 1'b1;
    bcd   = v;
    @(posedge clk); #1;
    start = 1'b0;
    bcd   = ~v;
    lat     = 0;
    busy_ok = busy;
    do begin
      @(posedge clk); #1;
      lat++;
      if (valid) break;
      if (!busy) busy_ok = 1'b0;
    end while (lat < 100);
    b = bin;
    e = err;
  endtask

  task automatic test_reset();
    nrst  = 1'b0;
    start = 1'b0;
    bcd   = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bin, valid, err, busy} !== 17'd0) begin
      errors++;
      $display("FAIL reset_state: bin=%0d valid=%b err=%b busy=%b, required all 0", bin, valid, err, busy);
    end
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [13:0] b; logic e; int lat; bit bok;
    run_conv(16'h4095, b, e, lat, bok);
    checks++;
    if (lat !== 15) begin errors++; $display("FAIL basic_latency: got %0d edges, required 15", lat); end
    checks++;
    if (b !== 14'(ref_bin(16'h4095)) || e !== 1'b0) begin
      errors++; $display("FAIL basic_4095: bin=%0d err=%b, required bin=%0d err=0", b, e, ref_bin(16'h4095));
    end
    checks++;
    if (bok !== 1'b1) begin errors++; $display("FAIL basic_busy: busy dropped during conversion, required 1"); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0 || bin !== 14'd4095 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_hold: valid=%b bin=%0d busy=%b, required valid=0 bin=4095 busy=0", valid, bin, busy);
    end
  endtask

  task automatic test_values();
    logic [15:0] vec [3] = '{16'h9999, 16'h0000, 16'h0001};
    logic [13:0] b; logic e; int lat; bit bok;
    foreach (vec[k]) begin
      run_conv(vec[k], b, e, lat, bok);
      checks++;
      if (lat !== 15 || b !== 14'(ref_bin(vec[k])) || e !== 1'b0) begin
        errors++;
        $display("FAIL value_%h: lat=%0d bin=%0d err=%b, required lat=15 bin=%0d err=0", vec[k], lat, b, e, ref_bin(vec[k]));
      end
    end
  endtask

  task automatic test_err();
    logic [13:0] b; logic e; int lat; bit bok;
    run_conv(16'h12A4, b, e, lat, bok);
    checks++;
    if (lat !== 15 || b !== 14'd0 || e !== 1'b1) begin
      errors++; $display("FAIL err_12A4: lat=%0d bin=%0d err=%b, required lat=15 bin=0 err=1", lat, b, e);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1 || valid !== 1'b0) begin
      errors++; $display("FAIL err_hold: err=%b valid=%b, required err=1 valid=0", err, valid);
    end
    run_conv(16'h0123, b, e, lat, bok);
    checks++;
    if (b !== 14'(ref_bin(16'h0123)) || e !== 1'b0) begin
      errors++; $display("FAIL err_recover: bin=%0d err=%b, required bin=123 err=0", b, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] b; logic e; int lat; bit bok; int n; int extra;
    start = 1'b1; bcd = 16'h0500;
    @(posedge clk); #1;
    start = 1'b0; bcd = '0;
    n = 0;
    repeat (3) begin @(posedge clk); #1; n++; end
    start = 1'b1; bcd = 16'h0777;
    @(posedge clk); #1;
    n++;
    start = 1'b0; bcd = '0;
    while (!valid && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 15 || bin !== 14'd500 || err !== 1'b0) begin
      errors++; $display("FAIL busy_ignore: lat=%0d bin=%0d err=%b, required lat=15 bin=500 err=0", n, bin, err);
    end
    run_conv(16'h0777, b, e, lat, bok);
    checks++;
    if (lat !== 15 || b !== 14'd777 || e !== 1'b0) begin
      errors++; $display("FAIL start_in_valid: lat=%0d bin=%0d err=%b, required lat=15 bin=777 err=0", lat, b, e);
    end
    extra = 0;
    repeat (20) begin @(posedge clk); #1; if (valid) extra++; end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL no_queue: %0d extra valid pulses, required 0", extra); end
  endtask

  task automatic test_reset_abort();
    logic [13:0] b; logic e; int lat; bit bok; int seen;
    start = 1'b1; bcd = 16'h8888;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    nrst = 1'b0;
    #1;
    checks++;
    if ({bin, valid, err, busy} !== 17'd0) begin
      errors++; $display("FAIL abort_clear: bin=%0d valid=%b err=%b busy=%b, required all 0", bin, valid, err, busy);
    end
    @(posedge clk); #1;
    nrst = 1'b1;
    seen = 0;
    repeat (25) begin @(posedge clk); #1; if (valid || busy) seen++; end
    checks++;
    if (seen !== 0 || bin !== 14'd0) begin
      errors++; $display("FAIL abort_no_valid: %0d active cycles bin=%0d, required 0 and bin=0", seen, bin);
    end
    run_conv(16'h0042, b, e, lat, bok);
    checks++;
    if (lat !== 15 || b !== 14'd42 || e !== 1'b0) begin
      errors++; $display("FAIL abort_recover: lat=%0d bin=%0d err=%b, required lat=15 bin=42 err=0", lat, b, e);
    end
  endtask

  task automatic test_random();
    logic [13:0] b; logic e; int lat; bit bok; logic [15:0] v;
    for (int n = 0; n < 1000; n++) begin
      for (int d = 0; d < 4; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      run_conv(v, b, e, lat, bok);
      checks++;
      if (lat !== 15 || b !== 14'(ref_bin(v)) || e !== 1'b0 || bok !== 1'b1) begin
        errors++;
        $display("FAIL random_%h: lat=%0d bin=%0d err=%b busy_ok=%b, required lat=15 bin=%0d err=0 busy_ok=1",
                 v, lat, b, e, bok, ref_bin(v));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_err();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd2bin_c.md
Name: bcd2bin_c

Overview:
- Serial reverse double-dabble converter: packed BCD digits in, unsigned binary out, one result bit resolved per clock.
- Inverse of the team's serial binary-to-BCD block.
- Sits on the UART command path: decimal values typed by the host (threshold, gain) are converted to binary before being written to the sobel/VGA control registers.
- Flags any non-decimal nibble instead of producing a silent wrong value.

Parameters:
- DIGITS, 4, number of BCD digits on input (bcd width = 4*DIGITS)
- BIN_W, 14, output width and iteration count; must satisfy 10^DIGITS <= 2^BIN_W

Ports:
- clk  input  1  system clock, rising edge
- nrst  input  1  asynchronous active-low reset
- start  input  1  request pulse; bcd sampled on the edge where start=1 and busy=0
- bcd  input  4*DIGITS  packed BCD, digit 0 in [3:0]
- bin  output  BIN_W  converted value, registered
- valid  output  1  one-cycle pulse: bin/err updated
- err  output  1  registered; set with valid if any input nibble > 9
- busy  output  1  conversion in progress

Behaviour:
- Reset and clock:
  - One clock; reset is asynchronous and active-low (clk, nrst).
  - Reset clears bin, valid, err, busy, iteration counter and all work registers to 0.
  - Reset mid-conversion aborts; no valid is produced for the aborted request.
- States: IDLE, RUN, DONE.
- IDLE:
  - On edge with start=1: load work vector W = {bcd, BIN_W'b0} (high part = BCD, low part = binary accumulator).
  - Compute err_pending = OR over digits of (nibble > 9).
  - Clear counter; go to RUN; busy=1.
- RUN: each edge, W <= adjust(W >> 1), counter++.
  - adjust: for every BCD digit field of the shifted vector, if digit >= 8 subtract 3, else unchanged.
  - All digits are adjusted in parallel, combinationally, in the same cycle.
  - After BIN_W iterations (counter == BIN_W-1 on that edge) go to DONE.
- DONE, exactly one edge:
  - bin <= low BIN_W bits of W, or 0 if err_pending.
  - err <= err_pending; valid <= 1; busy <= 0; go to IDLE.
- Latency: start sampled at edge E0 -> valid high in the cycle after edge E(BIN_W+1); 15 edges for the defaults.
- Output holding: valid is high for exactly one cycle; bin and err hold until the next valid.
- Start handling:
  - start while busy=1 is ignored; it is not queued and does not disturb the conversion in progress.
  - start in the same cycle valid is high is accepted, because busy is already 0. Back-to-back throughput is BIN_W+2 cycles per conversion.
  - bcd is only sampled at acceptance; input changes afterwards have no effect.
- Width rule: with a legal input every BCD digit field is 0 at the end of RUN; the final-iteration adjust is harmless.
- valid is never asserted without a preceding accepted start.

Test Plan:
- Reset, then bcd=16'h4095, start 1 cycle -> valid pulse 15 edges later, bin=14'd4095, err=0; busy high between acceptance and valid.
- bcd=16'h9999 -> bin=14'd9999; bcd=16'h0000 -> bin=0; bcd=16'h0001 -> bin=1; each with err=0.
- bcd=16'h12A4 -> valid after 15 edges, err=1, bin=0; a following bcd=16'h0123 -> err=0, bin=123.
- Start with 16'h0500; 3 cycles later start with 16'h0777 -> single valid, bin=500; a start in the valid cycle with 16'h0777 -> next valid, bin=777.
- Start with 16'h8888, drop nrst for 1 cycle at iteration 6 -> all outputs 0 and no valid; a new start with 16'h0042 -> bin=42.
- Random legal 4-digit BCD, 1000 vectors, compared against a decimal reference model -> zero mismatches and err always 0.
